// File: rtl/call_return_ctrl.sv
// Call/return controller in front of the return-address stack.
// Turns decode call/ret events into stack push/pop and feeds fetch.
module call_return_ctrl #(
  parameter int WL = 32,
  parameter int N  = 32,
  localparam int DW = $clog2(N) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          call,
  input  logic          ret,
  input  logic [WL-1:0] pc_plus4,
  input  logic          full,
  input  logic          empty,
  input  logic          error,
  input  logic [WL-1:0] data,
  output logic          push,
  output logic          pop,
  output logic [WL-1:0] dio,
  output logic [WL-1:0] ret_addr,
  output logic          ret_valid,
  output logic          stall,
  output logic [DW-1:0] depth,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_POP_WAIT = 2'd1;
  localparam logic [1:0] S_REPL     = 2'd2;

  logic [1:0]    r_state;
  logic          r_push;
  logic          r_pop;
  logic [WL-1:0] r_dio;
  logic [WL-1:0] r_ret_addr;
  logic          r_ret_valid;
  logic          r_stall;
  logic [DW-1:0] r_depth;
  logic          r_overflow;
  logic          r_underflow;
  logic [WL-1:0] r_link;
  logic          r_have_cmd;
  logic          r_last_pop;

  logic [DW-1:0] w_depth_inc;
  logic [DW-1:0] w_depth_dec;
  logic          w_last_pop;
  logic          w_err_valid;

  assign w_depth_inc = (r_depth == DW'(N)) ? r_depth : r_depth + 1'b1;
  assign w_depth_dec = (r_depth == '0) ? r_depth : r_depth - 1'b1;

  // The command the stack just saw is the one on the outputs this cycle
  assign w_last_pop  = r_pop ? 1'b1 : (r_push ? 1'b0 : r_last_pop);
  assign w_err_valid = error && (r_have_cmd || r_push || r_pop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_dio       <= '0;
      r_ret_addr  <= '0;
      r_ret_valid <= 1'b0;
      r_stall     <= 1'b0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_link      <= '0;
      r_have_cmd  <= 1'b0;
      r_last_pop  <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_ret_valid <= 1'b0;

      if (r_push || r_pop) begin
        r_have_cmd <= 1'b1;
        r_last_pop <= r_pop;
      end

      if (w_err_valid) begin
        if (w_last_pop) r_underflow <= 1'b1;
        else            r_overflow  <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (call && ret && !empty) begin
            // Tail call: pop now, push the new link once the pop is done
            r_pop   <= 1'b1;
            r_stall <= 1'b1;
            r_link  <= pc_plus4;
            r_state <= S_REPL;
          end else if (call) begin
            if (!full) begin
              r_push  <= 1'b1;
              r_dio   <= pc_plus4;
              r_depth <= w_depth_inc;
            end else begin
              r_overflow <= 1'b1;
            end
            if (ret) r_underflow <= 1'b1;
          end else if (ret) begin
            if (!empty) begin
              r_pop   <= 1'b1;
              r_stall <= 1'b1;
              r_depth <= w_depth_dec;
              r_state <= S_POP_WAIT;
            end else begin
              r_underflow <= 1'b1;
              r_ret_valid <= 1'b1;
              r_ret_addr  <= '0;
            end
          end
        end
        S_POP_WAIT: begin
          r_ret_addr  <= data;
          r_ret_valid <= 1'b1;
          r_stall     <= 1'b0;
          r_state     <= S_IDLE;
        end
        S_REPL: begin
          r_ret_addr  <= data;
          r_ret_valid <= 1'b1;
          r_push      <= 1'b1;
          r_dio       <= r_link;
          r_stall     <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_stall <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign push      = r_push;
  assign pop       = r_pop;
  assign dio       = r_dio;
  assign ret_addr  = r_ret_addr;
  assign ret_valid = r_ret_valid;
  assign stall     = r_stall;
  assign depth     = r_depth;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
